// File: rtl/traffic_phase_ctrl.sv
// Purpose : two-road (NS/EW) traffic-light phase sequencer driven by 1 s / 5 s timer ticks.
// Latency : 1 clk from the exiting tick to new lamps/phase; rst_count pulses for that one cycle.
// Backpressure: none; ticks seen while rst_count is high are dropped (timer is being cleared).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   one_sec_tick          1-cycle tick, counted in yellow / all-red phases
//   five_sec_tick         1-cycle tick, counted in green phases
//   ew_car                EW vehicle-present level; NS_GREEN only yields when set
//   rst_count             timer restart pulse on every phase entry
//   ns_light, ew_light    {red,yellow,green} one-hot lamp drives
//   phase                 current state code (debug)
//   ped_req, ns_walk      pedestrian request / NS WALK lamp, present only when
//                         the PED_WALK_EN macro is defined
module traffic_phase_ctrl #(
   parameter int GREEN_5S  = 2,
   parameter int YELLOW_1S = 3,
   parameter int ALLRED_1S = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       one_sec_tick,
   input  logic       five_sec_tick,
   input  logic       ew_car,
   output logic       rst_count,
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [2:0] phase
`ifdef PED_WALK_EN
   ,
   input  logic       ped_req,
   output logic       ns_walk
`endif
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      RED_A     = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      RED_B     = 3'd5
   } state_t;

   localparam logic [2:0] LAMP_RED    = 3'b100;
   localparam logic [2:0] LAMP_YELLOW = 3'b010;
   localparam logic [2:0] LAMP_GREEN  = 3'b001;

   state_t     state_q, state_d;
   logic [3:0] phase_cnt_q, phase_cnt_d;
   logic       rst_count_q, rst_count_d;
   logic [2:0] ns_light_q, ns_light_d;
   logic [2:0] ew_light_q, ew_light_d;

   logic       tick;        // tick of the current phase's unit, accepted
   logic [3:0] target;      // dwell length of the current phase, in its unit
   logic       ns_yield;    // NS_GREEN allowed to leave at its exit point
   logic       ns_green_entry;

`ifdef PED_WALK_EN
   logic       req_q, req_d;
   logic       ns_walk_q, ns_walk_d;
   logic       req_pend;
`endif

   always_comb begin
      tick   = 1'b0;
      target = 4'd1;
      case (state_q)
         NS_GREEN, EW_GREEN: begin
            tick   = five_sec_tick;
            target = 4'(GREEN_5S);
         end
         NS_YELLOW, EW_YELLOW: begin
            tick   = one_sec_tick;
            target = 4'(YELLOW_1S);
         end
         default: begin
            tick   = one_sec_tick;
            target = 4'(ALLRED_1S);
         end
      endcase
      // The timer is being restarted this cycle; whatever it emits is stale.
      if (rst_count_q)
         tick = 1'b0;

`ifdef PED_WALK_EN
      req_pend = req_q | ped_req;
      // A waiting request, or the walk currently being served, forces NS to yield.
      ns_yield = ew_car | req_q | ns_walk_q;
`else
      ns_yield = ew_car;
`endif

      state_d     = state_q;
      phase_cnt_d = phase_cnt_q;
      rst_count_d = 1'b0;

      if (tick) begin
         if (phase_cnt_q == target - 4'd1) begin
            phase_cnt_d = 4'd0;
            if (state_q == NS_GREEN && !ns_yield) begin
               // No EW demand: re-arm NS_GREEN silently, timer keeps running.
               state_d = NS_GREEN;
            end else begin
               rst_count_d = 1'b1;
               case (state_q)
                  NS_GREEN:  state_d = NS_YELLOW;
                  NS_YELLOW: state_d = RED_A;
                  RED_A:     state_d = EW_GREEN;
                  EW_GREEN:  state_d = EW_YELLOW;
                  EW_YELLOW: state_d = RED_B;
                  default:   state_d = NS_GREEN;
               endcase
            end
         end else begin
            phase_cnt_d = phase_cnt_q + 4'd1;
         end
      end

      ns_green_entry = (state_d == NS_GREEN) && (state_q != NS_GREEN);

      ns_light_d = LAMP_RED;
      ew_light_d = LAMP_RED;
      case (state_d)
         NS_GREEN:  ns_light_d = LAMP_GREEN;
         NS_YELLOW: ns_light_d = LAMP_YELLOW;
         EW_GREEN:  ew_light_d = LAMP_GREEN;
         EW_YELLOW: ew_light_d = LAMP_YELLOW;
         default:   ;
      endcase

`ifdef PED_WALK_EN
      if (ns_green_entry) begin
         ns_walk_d = req_pend;
         req_d     = 1'b0;
      end else begin
         ns_walk_d = (state_d == NS_GREEN) ? ns_walk_q : 1'b0;
         req_d     = req_pend;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RED_B;
         phase_cnt_q <= 4'd0;
         rst_count_q <= 1'b1;
         ns_light_q  <= LAMP_RED;
         ew_light_q  <= LAMP_RED;
`ifdef PED_WALK_EN
         req_q       <= 1'b0;
         ns_walk_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         phase_cnt_q <= phase_cnt_d;
         rst_count_q <= rst_count_d;
         ns_light_q  <= ns_light_d;
         ew_light_q  <= ew_light_d;
`ifdef PED_WALK_EN
         req_q       <= req_d;
         ns_walk_q   <= ns_walk_d;
`endif
      end
   end

   assign rst_count = rst_count_q;
   assign ns_light  = ns_light_q;
   assign ew_light  = ew_light_q;
   assign phase     = state_q;
`ifdef PED_WALK_EN
   assign ns_walk   = ns_walk_q;
`endif

endmodule
